bitfusion_weight_loader: RTL and testbench
==========================================

# bitfusion_weight_loader

Streams packed weight words from the on-chip weight memory into one BitFusion column. Each tile of `ROWS` words is collected into a shadow bank, then written to the column's per-row weight-buffer inputs with a one-cycle-per-row diagonal skew. The skew matches the PE partial-sum register chain. Weights are then held stationary for a programmable number of cycles before the next tile is accepted. Sits between the weight SRAM read port (producer) and the column's `WBUF_data_in_*` ports (consumer).

## Interface
- `ROWS`, 16, number of PE rows in the column (one weight word per row per tile)
- `DW`, 32, weight word width (packed 2/4/8-bit sub-weights; never interpreted here)
- `HW`, 8, width of the hold-length field

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `flush`  in  1  synchronous abort; returns to FILL, discards partial tile
- `s_valid`  in  1  producer word valid
- `s_ready`  out  1  loader can accept a word
- `s_data`  in  DW  weight word; the k-th accepted word of a tile is for row k+1
- `hold_len`  in  HW  stationary cycles after issue; sampled on FILL→ISSUE
- `wbuf_data`  out  ROWS*DW  flattened row outputs; row r (1-based) at bits [r*DW-1:(r-1)*DW]
- `busy`  out  1  high in ISSUE or HOLD
- `tile_done`  out  1  one-cycle pulse when a tile's hold period ends

## Operation
- States:
  - FILL (reset state): `s_ready`=1. Each `s_valid&&s_ready` writes `shadow[cnt]` and increments `cnt`.
  - On the handshake with `cnt`==ROWS-1: `cnt`←0, `hold_q`←`hold_len`, next state is ISSUE.
  - ISSUE: `s_ready`=0. In ISSUE cycle k (k=0..ROWS-1), row k+1 output register ← `shadow[k]`. After k=ROWS-1, go to HOLD if `hold_q`≠0, else to FILL with `tile_done` asserted.
  - HOLD: counter runs down from `hold_q`. When it reaches 1, go to FILL with `tile_done` asserted.
- Rows not yet reached in ISSUE keep the previous tile's value. Outputs are never zeroed except by reset.
- `flush` has priority over every transition:
  - next state FILL, `cnt`←0, `tile_done` not asserted;
  - `wbuf_data` retains its current values, including a partially skewed tile;
  - a handshake in the same cycle as `flush` is dropped.
- `s_data` is captured only on a handshake. `s_valid` low in FILL stalls without state change.
- No arithmetic on data. Counters: `cnt` is clog2(ROWS) bits, wraps only by explicit clear. The hold counter is HW bits.
- Reset values: state FILL, `cnt` 0, `wbuf_data` all 0, `s_ready` 1, `busy` 0, `tile_done` 0. Shadow contents are don't-care.

## Timing
- `s_ready` and `busy` are Moore outputs decoded from state. `tile_done` is registered.
- Last FILL handshake at edge T:
  - row 1 output changes at edge T+1;
  - row r output changes at edge T+r;
  - row ROWS output changes at T+ROWS.
- ISSUE lasts exactly ROWS cycles. HOLD lasts exactly `hold_q` cycles.
- `tile_done` is high in the first FILL cycle after a completed tile. `s_ready` is high in that same cycle.
- Minimum tile period with back-to-back producer: ROWS (fill) + ROWS (issue) + `hold_q` cycles.
- `reset` deassertion is synchronized externally. The first handshake is possible on the first edge after release.
- `reset` asserted mid-ISSUE or mid-HOLD clears everything immediately (asynchronously) to reset values.

## Structure
- Shared package `bitfusion_pkg`: `ROWS`/`DW` defaults and the state enum `{FILL, ISSUE, HOLD}`. The column top uses the same row-count constant.
- Single module. The row output bank is a natural sub-module, `skew_reg_bank`: ROWS×DW registers with a one-hot row write-enable from the ISSUE index, async active-low clear.

## Test plan
- Basic tile:
  - stimulus: ROWS=16, words 0x0000_0001..0x0000_0010 back-to-back, `hold_len`=0;
  - required: row r = r at edge T+r, `busy` high 16 cycles, `tile_done` at T+17, `s_ready` low T+1..T+16.
- Hold:
  - stimulus: `hold_len`=5, second tile offered immediately;
  - required: `s_ready` stays low for 16+5 cycles; `tile_done` exactly once, in the first FILL cycle after HOLD; 5 is sampled even if `hold_len` changes during ISSUE.
- Stalled producer:
  - stimulus: random `s_valid` gaps during FILL;
  - required: word order is preserved, row 7 gets the 7th accepted word, no spurious writes.
- Flush:
  - stimulus 1: `flush` after 9 words;
  - required: next 16 words form a clean tile; `wbuf_data` unchanged until the new ISSUE.
  - stimulus 2: `flush` at ISSUE k=4;
  - required: rows 1–4 new, rows 5–16 old, no `tile_done`.
- Async reset:
  - stimulus: `reset`=0 mid-HOLD between clock edges;
  - required: all `wbuf_data` 0 and `busy` 0 immediately, `s_ready` 1.
- Simultaneous events:
  - stimulus 1: `flush` coinciding with the 16th handshake;
  - required: stays FILL, `cnt`=0, word dropped.
  - stimulus 2: `s_valid` high while `tile_done` is high;
  - required: word accepted as row 1 of the next tile.

Source files
------------

// File: rtl/bitfusion_pkg.sv
// Shared BitFusion column constants and the weight-loader state encoding.
// The column top uses the same row-count constant so both stay in step.
package bitfusion_pkg;

    localparam int BF_ROWS = 16;
    localparam int BF_DW   = 32;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/skew_reg_bank.sv
// Per-row weight output registers for one column; each row loads only when its
// one-hot write enable is set, so untouched rows keep the previous tile's word.
module skew_reg_bank #(
    parameter int ROWS = 16,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS-1:0]      row_we,
    input  logic [DW-1:0]        row_data,
    output logic [ROWS*DW-1:0]   rows
);

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [DW-1:0] row_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    row_reg <= '0;
                end else if (row_we[gi]) begin
                    row_reg <= row_data;
                end
            end

            assign rows[gi*DW +: DW] = row_reg;
        end
    endgenerate

endmodule

// File: rtl/bitfusion_weight_loader.sv
// Collects ROWS weight words into a shadow bank, writes them to the column rows one
// row per cycle (diagonal skew), then holds them stationary for hold_len cycles.
module bitfusion_weight_loader
    import bitfusion_pkg::*;
#(
    parameter int ROWS = BF_ROWS,
    parameter int DW   = BF_DW,
    parameter int HW   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic [HW-1:0]        hold_len,
    output logic [ROWS*DW-1:0]   wbuf_data,
    output logic                 busy,
    output logic                 tile_done
);

    localparam int CW = $clog2(ROWS);
    localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

    loader_state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic          tile_done_reg, tile_done_next;
    logic          shadow_we;
    logic [ROWS-1:0] row_we;

    logic [DW-1:0] shadow [ROWS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= FILL;
            cnt_reg       <= '0;
            hold_reg      <= '0;
            tile_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hold_reg      <= hold_next;
            tile_done_reg <= tile_done_next;
        end
    end

    // cnt doubles as the fill index and the ISSUE row index; both start from 0.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hold_next      = hold_reg;
        tile_done_next = 1'b0;
        shadow_we      = 1'b0;
        row_we         = '0;

        case (state_reg)
            FILL: begin
                if (s_valid) begin
                    shadow_we = 1'b1;
                    if (cnt_reg == LAST) begin
                        cnt_next   = '0;
                        hold_next  = hold_len;
                        state_next = ISSUE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ISSUE: begin
                row_we[cnt_reg] = 1'b1;
                if (cnt_reg == LAST) begin
                    cnt_next = '0;
                    if (hold_reg != '0) begin
                        state_next = HOLD;
                    end else begin
                        state_next     = FILL;
                        tile_done_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (hold_reg <= HW'(1)) begin
                    state_next     = FILL;
                    tile_done_next = 1'b1;
                end else begin
                    hold_next = hold_reg - 1'b1;
                end
            end
            default: begin
                state_next = FILL;
                cnt_next   = '0;
            end
        endcase

        // Abort wins: no shadow or row write, partial tile discarded, outputs frozen.
        if (flush) begin
            state_next     = FILL;
            cnt_next       = '0;
            hold_next      = hold_reg;
            tile_done_next = 1'b0;
            shadow_we      = 1'b0;
            row_we         = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow[cnt_reg] <= s_data;
        end
    end

    skew_reg_bank #(
        .ROWS (ROWS),
        .DW   (DW)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .row_we   (row_we),
        .row_data (shadow[cnt_reg]),
        .rows     (wbuf_data)
    );

    assign s_ready   = (state_reg == FILL);
    assign busy      = (state_reg == ISSUE) || (state_reg == HOLD);
    assign tile_done = tile_done_reg;

endmodule

// File: tb/tb_bitfusion_weight_loader.sv
// Randomized bench for bitfusion_weight_loader against a timeline model: a completed
// tile at edge T lands row r at T+r and finishes at T+ROWS+hold.
module tb_bitfusion_weight_loader;
    import bitfusion_pkg::*;

    localparam int ROWS = BF_ROWS;
    localparam int DW   = BF_DW;
    localparam int HW   = 8;

    typedef logic [ROWS*DW-1:0] vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic [HW-1:0]   hold_len = '0;
    logic            s_ready;
    logic            busy;
    logic            tile_done;
    vec_t            wbuf_data;

    always #5 clk = ~clk;

    bitfusion_weight_loader #(
        .ROWS (ROWS),
        .DW   (DW),
        .HW   (HW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .hold_len  (hold_len),
        .wbuf_data (wbuf_data),
        .busy      (busy),
        .tile_done (tile_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] exp_rows [ROWS];
    logic [DW-1:0] tile_words [ROWS];
    logic [DW-1:0] fill_q [$];
    int  tile_t = -1;
    int  tile_hold = 0;
    int  edge_n = 0;
    int  tiles_seen = 0;
    bit  exp_done = 1'b0;

    function automatic vec_t flat_rows();
        vec_t v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = exp_rows[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) exp_rows[r] = '0;
        fill_q.delete();
        tile_t   = -1;
        exp_done = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit fl,
                              input logic [HW-1:0] hl);
        int p;
        exp_done = 1'b0;
        if (fl) begin
            fill_q.delete();
            tile_t = -1;
            $display("[TB] flush at edge %0d", edge_n);
        end else if (tile_t < 0) begin
            if (v) begin
                fill_q.push_back(d);
                if (fill_q.size() == ROWS) begin
                    for (int r = 0; r < ROWS; r++) tile_words[r] = fill_q[r];
                    fill_q.delete();
                    tile_t    = edge_n;
                    tile_hold = int'(hl);
                end
            end
        end else begin
            p = edge_n - tile_t;
            if (p >= 1 && p <= ROWS) exp_rows[p-1] = tile_words[p-1];
            if (p == ROWS + tile_hold) begin
                exp_done = 1'b1;
                tile_t   = -1;
                tiles_seen++;
                $display("[TB] tile %0d done at edge %0d hold=%0d", tiles_seen, edge_n, tile_hold);
            end
        end
    endtask

    task automatic check_outputs(input string ctx);
        check_eq({ctx, ".s_ready"},   vec_t'(s_ready),   vec_t'(tile_t < 0));
        check_eq({ctx, ".busy"},      vec_t'(busy),      vec_t'(tile_t >= 0));
        check_eq({ctx, ".tile_done"}, vec_t'(tile_done), vec_t'(exp_done));
        check_eq({ctx, ".wbuf"},      wbuf_data,         flat_rows());
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit fl,
                        input logic [HW-1:0] hl);
        s_valid  = v;
        s_data   = d;
        flush    = fl;
        hold_len = hl;
        @(posedge clk);
        edge_n++;
        model_edge(v, d, fl, hl);
        #1;
        check_outputs("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Basic tile: words 1..16, no hold
        for (int i = 1; i <= ROWS; i++) step(1'b1, DW'(i), 1'b0, '0);
        idle(20);

        // Hold of 5 with a producer that never stops offering; hold_len wiggles later
        for (int i = 1; i <= ROWS; i++) step(1'b1, 32'h100 + DW'(i), 1'b0, 8'd5);
        for (int i = 0; i < 60; i++)
            step(1'b1, $urandom, 1'b0, HW'($urandom_range(0, 3)));
        idle(40);

        // Flush after 9 words, then a clean tile
        for (int i = 0; i < 9; i++) step(1'b1, 32'hA000 + DW'(i), 1'b0, '0);
        step(1'b0, '0, 1'b1, '0);
        for (int i = 0; i < ROWS; i++) step(1'b1, 32'hB000 + DW'(i), 1'b0, '0);
        idle(20);

        // Flush during ISSUE k=4
        for (int i = 0; i < ROWS; i++) step(1'b1, 32'hC000 + DW'(i), 1'b0, 8'd2);
        idle(4);
        step(1'b0, '0, 1'b1, '0);
        idle(30);

        // Flush together with the 16th handshake
        for (int i = 0; i < ROWS - 1; i++) step(1'b1, 32'hD000 + DW'(i), 1'b0, '0);
        step(1'b1, 32'hDEAD, 1'b1, '0);
        for (int i = 0; i < ROWS; i++) step(1'b1, 32'hE000 + DW'(i), 1'b0, '0);
        idle(25);

        // Stalled producer with rare flushes
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 1,
                 HW'($urandom_range(0, 6)));
        idle(40);

        // Async reset in the middle of a long HOLD
        for (int i = 0; i < ROWS; i++) step(1'b1, 32'hF000 + DW'(i), 1'b0, 8'd20);
        idle(ROWS + 3);
        check_eq("pre_reset.busy", vec_t'(busy), vec_t'(1'b1));
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge clk);
        reset = 1'b1;

        // Handshake on the first edge after release
        for (int i = 0; i < ROWS; i++) step(1'b1, $urandom, 1'b0, 8'd1);
        idle(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
